cpu_datapath: RTL

// Multi-cycle CPU datapath that executes the per-state control word issued by FSM_Control.

---
 rtl/cpu_datapath.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - multi-cycle CPU datapath: register file, IR, MDR, status and ALU
//
// Executes one control word per cycle from the external FSM controller.
// The program counter is register-file entry PC_INDEX.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   status_we                 load status from the ALU result
//   alu_op[2:0]               000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, others -> 0
//   alu_in0                   0 = out0, 1 = PC
//   alu_in1[1:0]              00 = out1, 01 = sext(IR[7:0]), 10 = 1, 11 = 0
//   memory_write              memory write strobe, forwarded to mem_we
//   memory_addr[1:0]          00 = PC, 01 = out0, 10 = out1, 11 = PC
//   ins_reg                   load IR from mem_rdata
//   reg_data[1:0]             00 = zext(IR[7:0]), 01 = MDR, 10 = ALU, 11 = out1
//   reg_addr[1:0]             00 = IR[11:8], 01 = IR[7:4], 10 = PC_INDEX, 11 = no write
//   regfile_write             register-file write enable
//   opcode[3:0]               IR[15:12]
//   status[1:0]               {ZERO, NEG}
//   mem_addr, mem_wdata       memory address / store data (out1)
//   mem_we                    memory write enable
//   mem_rdata                 synchronous-read memory data, one cycle latency

module cpu_datapath #(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 16,
    parameter int PC_INDEX  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              status_we,
    input  logic [2:0]        alu_op,
    input  logic              alu_in0,
    input  logic [1:0]        alu_in1,
    input  logic              memory_write,
    input  logic [1:0]        memory_addr,
    input  logic              ins_reg,
    input  logic [1:0]        reg_data,
    input  logic [1:0]        reg_addr,
    input  logic              regfile_write,
    output logic [3:0]        opcode,
    output logic [1:0]        status,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] PC_SEL  = 4'(PC_INDEX);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;
    logic [1:0]        status_q;

    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_idx;
    logic              wr_en;

    // Read ports see the pre-edge contents, so a same-cycle write is not forwarded.
    assign out0     = regs[ir[7:4]];
    assign out1     = regs[ir[3:0]];
    assign pc       = regs[PC_SEL];
    assign imm_sext = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign imm_zext = {{(DATA_W-8){1'b0}}, ir[7:0]};

    assign opcode    = ir[15:12];
    assign status    = status_q;
    assign mem_wdata = out1;
    assign mem_we    = memory_write;

    always_comb begin
        alu_a = alu_in0 ? pc : out0;
    end

    always_comb begin
        case (alu_in1)
            2'b00:   alu_b = out1;
            2'b01:   alu_b = imm_sext;
            2'b10:   alu_b = {{(DATA_W-1){1'b0}}, 1'b1};
            default: alu_b = '0;
        endcase
    end

    // Arithmetic wraps modulo 2^DATA_W; there is no carry flag.
    always_comb begin
        case (alu_op)
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_XOR: alu_res = alu_a ^ alu_b;
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (memory_addr)
            2'b01:   mem_addr = out0;
            2'b10:   mem_addr = out1;
            default: mem_addr = pc;
        endcase
    end

    always_comb begin
        case (reg_data)
            2'b00:   wr_data = imm_zext;
            2'b01:   wr_data = mdr;
            2'b10:   wr_data = alu_res;
            default: wr_data = out1;
        endcase
    end

    // reg_addr 11 has no destination; it masks regfile_write entirely.
    always_comb begin
        wr_en  = regfile_write;
        wr_idx = ir[11:8];
        case (reg_addr)
            2'b00:   wr_idx = ir[11:8];
            2'b01:   wr_idx = ir[7:4];
            2'b10:   wr_idx = PC_SEL;
            default: wr_en  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            ir       <= '0;
            mdr      <= '0;
            status_q <= '0;
        end else begin
            mdr <= mem_rdata;
            if (ins_reg) begin
                ir <= mem_rdata;
            end
            if (status_we) begin
                status_q <= {alu_res == '0, alu_res[DATA_W-1]};
            end
            if (wr_en) begin
                regs[wr_idx] <= wr_data;
            end
        end
    end

endmodule
